uart_rx_oversample: RTL and testbench

//  Serial UART receiver; consumes the line driven by the UART transmitter (8N1, LSB first).

---
 rtl/uart_rx_oversample.sv | 157 +++++++++++++++
 tb/tb_uart_rx_oversample.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// UART receiver, 8N1 LSB first, oversampled by baud_tick.
// A falling edge is qualified at mid start bit. Each data bit is sampled
// at mid-bit, and the stop bit is checked before the byte is published.
module uart_rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 err_n;
  logic                 done_n;

  // Two-flop synchronizer. It resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      o_data    <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      o_data    <= data_n;
      frame_err <= err_n;
      rx_done   <= done_n;
    end
  end

  // Next-state logic. Counting advances only on baud_tick cycles.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = o_data;
    err_n   = frame_err;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          tick_n  = '0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_n = '0;
            if (!rx_s) begin
              state_n = S_DATA;
              bit_n   = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_n  = '0;
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_n = S_STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_n  = '0;
            data_n  = shift;
            err_n   = ~rx_s;
            done_n  = 1'b1;
            state_n = rx_s ? S_IDLE : S_BREAK;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Busy whenever a frame is being tracked, including a held-low break.
  always_comb begin
    rx_busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample.
// Expected frames are queued when sent and popped on each rx_done.
module tb_uart_rx_oversample;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic [7:0] o_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   tick_div = 0;
  exp_t sb[$];

  logic [7:0] hold_d = '0;
  logic       hold_e = 1'b0;
  logic       prev_done = 1'b0;

  uart_rx_oversample #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx        (rx),
    .o_data    (o_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide pulse every TICK_DIV clocks.
  always @(negedge clk) begin
    tick_div  = (tick_div + 1) % TICK_DIV;
    baud_tick = (tick_div == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops and a hold check between frames.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_d    = '0;
      hold_e    = 1'b0;
      prev_done = 1'b0;
    end else if (rx_done) begin
      exp_t e;
      done_cnt++;
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("o_data", {24'd0, o_data}, {24'd0, e.d});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.e});
      end
      hold_d    = o_data;
      hold_e    = frame_err;
      prev_done = 1'b1;
    end else begin
      check("o_data_hold", {24'd0, o_data}, {24'd0, hold_d});
      check("frame_err_hold", {31'd0, frame_err}, {31'd0, hold_e});
      prev_done = 1'b0;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc, input bit push);
    if (push) sb.push_back('{d: d, e: ~stop});
    rx = 1'b0;
    hold(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(bc);
    end
    rx = stop;
    hold(bc);
  endtask

  initial begin
    int         base;
    logic [7:0] c3;

    rst_n = 1'b0;
    rx    = 1'b1;
    hold(3);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    hold(BIT_CLKS);

    // Single frame A5.
    send_frame(8'hA5, 1'b1, BIT_CLKS, 1'b1);
    hold(BIT_CLKS);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_sb_empty", sb.size(), 32'd0);

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, BIT_CLKS, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_CLKS, 1'b1);
    send_frame(8'h3C, 1'b1, BIT_CLKS, 1'b1);
    hold(BIT_CLKS);
    check("t2_done_cnt", done_cnt, 32'd4);
    check("t2_sb_empty", sb.size(), 32'd0);

    // Glitch: low for 4 ticks only.
    base = done_cnt;
    rx = 1'b0;
    hold(10);
    check("t3_busy_in_start", {31'd0, rx_busy}, 32'd1);
    hold(4 * TICK_DIV - 10);
    rx = 1'b1;
    hold(40);
    check("t3_busy_fell", {31'd0, rx_busy}, 32'd0);
    hold(BIT_CLKS * 2);
    check("t3_no_done", done_cnt, base);

    // Framing error followed by a long break, then a good frame.
    base = done_cnt;
    send_frame(8'h55, 1'b0, BIT_CLKS, 1'b1);
    hold(29 * BIT_CLKS);
    check("t4_one_done", done_cnt, base + 1);
    check("t4_busy_break", {31'd0, rx_busy}, 32'd1);
    check("t4_err_held", {31'd0, frame_err}, 32'd1);
    rx = 1'b1;
    hold(2 * BIT_CLKS);
    check("t4_idle_after_break", {31'd0, rx_busy}, 32'd0);
    check("t4_no_retrigger", done_cnt, base + 1);
    send_frame(8'h12, 1'b1, BIT_CLKS, 1'b1);
    hold(BIT_CLKS);
    check("t4_err_cleared", {31'd0, frame_err}, 32'd0);
    check("t4_sb_empty", sb.size(), 32'd0);

    // Reset mid-frame, then a clean frame.
    base = done_cnt;
    c3 = 8'hC3;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      hold(BIT_CLKS);
    end
    #2;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("t5_o_data_zero", {24'd0, o_data}, 32'd0);
    check("t5_busy_zero", {31'd0, rx_busy}, 32'd0);
    check("t5_done_zero", {31'd0, rx_done}, 32'd0);
    check("t5_err_zero", {31'd0, frame_err}, 32'd0);
    hold(3);
    #2;
    rst_n = 1'b1;
    hold(BIT_CLKS * 6);
    check("t5_no_done", done_cnt, base);
    send_frame(8'h81, 1'b1, BIT_CLKS, 1'b1);
    hold(BIT_CLKS);
    check("t5_done_cnt", done_cnt, base + 1);
    check("t5_sb_empty", sb.size(), 32'd0);

    // Transmitter bit time skewed by +3% and -3%.
    send_frame(8'h96, 1'b1, BIT_CLKS + 2, 1'b1);
    hold(BIT_CLKS);
    send_frame(8'h96, 1'b1, BIT_CLKS - 2, 1'b1);
    hold(BIT_CLKS);
    check("t6_sb_empty", sb.size(), 32'd0);
    check("t6_done_cnt", done_cnt, base + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
